apb2tl: RTL and testbench
=========================

# apb2tl

APB3 completer to TileLink-UL manager bridge: accepts single 32-bit APB transfers and issues exactly one Get or PutFullData on the 64-bit TileLink A channel per transfer. It waits for the matching D-channel beat, then completes the APB access with the returned data and error status. It lets APB-only initiators (debug/DMA shims, test masters) reach TileLink memory and peripherals, and is the reverse of the TileLink-to-APB peripheral bridge. One transaction outstanding at a time.

## Interface
- APB_ADDR_WIDTH, 32, APB address width; zero-extended to the TL address width.
- APB_DATA_WIDTH, 32, APB data width; fixed at 32.
- ADDR_OFFSET, 0, constant added to the APB address to form the TL address (modulo TL address width).
- SOURCE_ID, 0, `tl_pkg::source_t` value driven on every A request.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB access phase.
- pwrite_i  in  1  1 = write.
- paddr_i  in  APB_ADDR_WIDTH  byte address; bits [1:0] ignored.
- pwdata_i  in  APB_DATA_WIDTH  write data.
- prdata_o  out  APB_DATA_WIDTH  read data, valid with pready_o.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error, valid with pready_o.
- TL_A_valid_o  out  1  A request valid.
- TL_A_ready_i  in  1  A request accepted.
- TL_A_bits_o  out  tl_pkg::A_chan_bits_t  A request payload.
- TL_D_valid_i  in  1  D response valid.
- TL_D_ready_o  out  1  D response accepted.
- TL_D_bits_i  in  tl_pkg::D_chan_bits_t  D response payload.

## Operation
- FSM states: IDLE, REQ, WAIT_D, RESP. Reset state is IDLE.
- IDLE:
  - On psel_i && !penable_i (setup phase), register pwrite_i, paddr_i and pwdata_i, then go to REQ.
  - Any other input combination is ignored.
- Request fields (registered, stable for the whole REQ state):
  - opcode: PutFullData if write, else Get.
  - param = 0; size = 2; source = SOURCE_ID; corrupt = 0.
  - address = paddr with bits [1:0] cleared, + ADDR_OFFSET.
  - If paddr[2]==0: mask 8'h0F, data = {32'h0, pwdata}.
  - If paddr[2]==1: mask 8'hF0, data = {pwdata, 32'h0}.
- REQ: TL_A_valid_o=1. On TL_A_ready_i, go to WAIT_D. The payload must not change while valid is high and ready is low.
- WAIT_D: TL_D_ready_o=1. On TL_D_valid_i, register the results below and go to RESP.
  - Read data: captured data[31:0] if captured paddr[2]==0, else data[63:32].
  - Error: denied, OR corrupt on AccessAckData, OR opcode mismatch (write expects AccessAck, read expects AccessAckData).
- RESP: pready_o=1 for exactly one cycle, with prdata_o and pslverr_o driven from registers. Then go to IDLE.
- prdata_o is 0 for writes and is 0 whenever pready_o=0. pslverr_o is 0 whenever pready_o=0.
- APB abort: if psel_i drops during REQ or WAIT_D, the TL transaction still completes. RESP is then entered but pready_o is suppressed, and the FSM returns to IDLE. TileLink requests are never withdrawn.
- Setup phases arriving while the FSM is not in IDLE are not accepted. This cannot happen under legal APB.

## Timing
- Reset values: TL_A_valid_o=0, TL_D_ready_o=0, pready_o=0, pslverr_o=0, prdata_o=0, TL_A_bits_o=0.
- Best-case sequence:
  - T0: setup phase.
  - T1: TL_A_valid_o=1; A ready in the same cycle.
  - T2: TL_D_ready_o=1; D valid in the same cycle.
  - T3: pready_o=1.
  - Result: 3-cycle access phase, 4 APB cycles total.
- Each stall cycle on TL_A_ready_i or TL_D_valid_i adds one cycle.
- TL_A_valid_o and TL_D_ready_o are never high in the same cycle.
- TL_D_ready_o=0 outside WAIT_D. A D beat presented early is held off, not dropped.
- Back-to-back transfers: the next setup phase may coincide with the cycle after RESP. No idle cycle is required beyond APB's own.
- Reset asserted mid-transfer: returns to IDLE on the next edge and all outputs take their reset values. The outstanding TL response is discarded by system reset.

## Test plan
- Write, paddr=0x104, pwdata=0xDEADBEEF, A/D ready and valid immediately -> A: PutFullData, address 0x104, mask 8'hF0, data 0xDEADBEEF_00000000, size 2. pready_o in the 3rd access cycle, pslverr_o=0.
- Read, paddr=0x200, D AccessAckData with data 0x11223344_55667788 -> A: Get, mask 8'h0F; prdata_o=0x55667788. Same read at paddr=0x204 -> prdata_o=0x11223344.
- TL_A_ready_i held low 5 cycles, then D delayed 3 cycles -> TL_A_bits_o stable throughout; pready_o one cycle after the D handshake; access phase 11 cycles.
- Read answered with D corrupt=1, then a write answered with denied=1, then a write answered with AccessAckData -> pslverr_o=1 in all three cases.
- psel_i dropped during WAIT_D -> D still accepted; pready_o never asserts; the next transfer completes normally.
- rst_i pulsed during REQ -> next cycle TL_A_valid_o=0 and FSM in IDLE; a following read completes correctly.

Source files
------------

// File: rtl/apb2tl.sv
// apb2tl: APB3 completer bridged onto a TileLink-UL A/D channel pair.
// A single APB transfer becomes one Get or PutFullData on the 64-bit bus.
// Only one transaction is in flight at a time.

package tl_pkg;
  localparam int AW    = 32;  // TL address width
  localparam int DW    = 64;  // TL data width
  localparam int DBW   = DW / 8;
  localparam int SRCW  = 8;
  localparam int SINKW = 1;

  typedef logic [SRCW-1:0] source_t;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;

  // D-channel opcodes
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic [2:0]     opcode;
    logic [2:0]     param;
    logic [2:0]     size;
    source_t        source;
    logic [AW-1:0]  address;
    logic [DBW-1:0] mask;
    logic           corrupt;
    logic [DW-1:0]  data;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       param;
    logic [2:0]       size;
    source_t          source;
    logic [SINKW-1:0] sink;
    logic             denied;
    logic             corrupt;
    logic [DW-1:0]    data;
  } D_chan_bits_t;
endpackage

module apb2tl #(
  parameter int                     APB_ADDR_WIDTH = 32,
  parameter int                     APB_DATA_WIDTH = 32,
  parameter logic [tl_pkg::AW-1:0]  ADDR_OFFSET    = '0,
  parameter tl_pkg::source_t        SOURCE_ID      = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // APB completer
  input  logic                        psel_i,
  input  logic                        penable_i,
  input  logic                        pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]   paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]   pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]   prdata_o,
  output logic                        pready_o,
  output logic                        pslverr_o,
  // TileLink manager port
  output logic                        TL_A_valid_o,
  input  logic                        TL_A_ready_i,
  output tl_pkg::A_chan_bits_t        TL_A_bits_o,
  input  logic                        TL_D_valid_i,
  output logic                        TL_D_ready_o,
  input  tl_pkg::D_chan_bits_t        TL_D_bits_i
);

  import tl_pkg::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  A_chan_bits_t              a_bits_q;   // request payload, frozen through REQ
  logic                      write_q;    // current transfer is a write
  logic                      hi_q;       // 32-bit lane is the upper half of the beat
  logic                      abort_q;    // initiator dropped psel mid-transfer
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;

  logic                      setup;
  logic [AW-1:0]             paddr_ext;
  logic [AW-1:0]             tl_addr;
  logic [APB_DATA_WIDTH-1:0] d_lane;
  logic                      d_err;
  logic                      unused_d_fields;

  assign setup = psel_i && !penable_i;

  // Word-align the APB address, zero-extend it, then relocate into TL space.
  assign paddr_ext = AW'(paddr_i);
  assign tl_addr   = (paddr_ext & ~AW'(3)) + ADDR_OFFSET;

  // Pick the half of the returned beat that matches the requested lane.
  assign d_lane = hi_q ? TL_D_bits_i.data[63:32] : TL_D_bits_i.data[31:0];

  // Denied, corrupted data, or an ack of the wrong kind all surface as PSLVERR.
  always_comb begin
    d_err = TL_D_bits_i.denied;
    if (TL_D_bits_i.opcode == ACCESS_ACK_DATA && TL_D_bits_i.corrupt)
      d_err = 1'b1;
    if (write_q && TL_D_bits_i.opcode != ACCESS_ACK)
      d_err = 1'b1;
    if (!write_q && TL_D_bits_i.opcode != ACCESS_ACK_DATA)
      d_err = 1'b1;
  end

  // Response fields that carry no meaning for a single-beat bridge.
  assign unused_d_fields = ^{TL_D_bits_i.param, TL_D_bits_i.size,
                             TL_D_bits_i.source, TL_D_bits_i.sink};

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: setup -> issue A -> await D -> one-cycle APB completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup)        state_d = REQ;
      REQ:     if (TL_A_ready_i) state_d = WAIT_D;
      WAIT_D:  if (TL_D_valid_i) state_d = RESP;
      RESP:                      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Capture the APB setup phase into the A-channel payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_bits_q <= '0;
      write_q  <= 1'b0;
      hi_q     <= 1'b0;
    end else if (state_q == IDLE && setup) begin
      write_q          <= pwrite_i;
      hi_q             <= paddr_i[2];
      a_bits_q.opcode  <= pwrite_i ? PUT_FULL_DATA : GET;
      a_bits_q.param   <= 3'd0;
      a_bits_q.size    <= 3'd2;
      a_bits_q.source  <= SOURCE_ID;
      a_bits_q.address <= tl_addr;
      a_bits_q.corrupt <= 1'b0;
      if (paddr_i[2]) begin
        a_bits_q.mask <= 8'hF0;
        a_bits_q.data <= {pwdata_i, 32'h0};
      end else begin
        a_bits_q.mask <= 8'h0F;
        a_bits_q.data <= {32'h0, pwdata_i};
      end
    end
  end

  // Remember an APB abort; the TL side still runs to completion.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      abort_q <= 1'b0;
    else if (state_q == IDLE && setup)
      abort_q <= 1'b0;
    else if ((state_q == REQ || state_q == WAIT_D) && !psel_i)
      abort_q <= 1'b1;
  end

  // Latch read data and error status on the D handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == WAIT_D && TL_D_valid_i) begin
      rdata_q <= write_q ? '0 : d_lane;
      err_q   <= d_err;
    end
  end

  // Outputs are pure functions of state so A-valid and D-ready never overlap.
  always_comb begin
    TL_A_valid_o = (state_q == REQ);
    TL_D_ready_o = (state_q == WAIT_D);
    TL_A_bits_o  = a_bits_q;
    pready_o     = (state_q == RESP) && !abort_q;
    prdata_o     = pready_o ? rdata_q : '0;
    pslverr_o    = pready_o ? err_q   : 1'b0;
  end

`ifndef SYNTHESIS
  a_d_exclusive : assert property (@(posedge clk_i) disable iff (rst_i)
    !(TL_A_valid_o && TL_D_ready_o));
  a_hold_valid  : assert property (@(posedge clk_i) disable iff (rst_i)
    TL_A_valid_o && !TL_A_ready_i |=> TL_A_valid_o);
  a_hold_bits   : assert property (@(posedge clk_i) disable iff (rst_i)
    TL_A_valid_o && !TL_A_ready_i |=> TL_A_bits_o == $past(TL_A_bits_o));
  resp_one_cyc  : assert property (@(posedge clk_i) disable iff (rst_i)
    pready_o |=> !pready_o);
`endif

endmodule

// File: tb/tb_apb2tl.sv
// tb_apb2tl: directed APB transfers against a scripted TileLink responder.
// Expected A payloads and APB responses are queued by the stimulus and
// popped by an independent monitor when the DUT presents them.

module tb_apb2tl;
  import tl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i, pwdata_i, prdata_o;
  logic        pready_o, pslverr_o;
  logic        TL_A_valid_o, TL_A_ready_i;
  A_chan_bits_t TL_A_bits_o;
  logic        TL_D_valid_i, TL_D_ready_o;
  D_chan_bits_t TL_D_bits_i;

  apb2tl #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .ADDR_OFFSET(32'h0), .SOURCE_ID(8'h00)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
    .pready_o(pready_o), .pslverr_o(pslverr_o),
    .TL_A_valid_o(TL_A_valid_o), .TL_A_ready_i(TL_A_ready_i), .TL_A_bits_o(TL_A_bits_o),
    .TL_D_valid_i(TL_D_valid_i), .TL_D_ready_o(TL_D_ready_o), .TL_D_bits_i(TL_D_bits_i)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int overlap_viol = 0;

  A_chan_bits_t exp_a_q[$];
  logic [32:0]  exp_r_q[$];   // {pslverr, prdata}

  task automatic chk(input bit ok, input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic A_chan_bits_t mk_a(input logic [2:0] op, input logic [31:0] addr,
                                        input logic [7:0] mask, input logic [63:0] data);
    A_chan_bits_t a;
    a.opcode = op; a.param = 3'd0; a.size = 3'd2; a.source = 8'h00;
    a.address = addr; a.mask = mask; a.corrupt = 1'b0; a.data = data;
    return a;
  endfunction

  function automatic D_chan_bits_t mk_d(input logic [2:0] op, input logic denied,
                                        input logic corrupt, input logic [63:0] data);
    D_chan_bits_t d;
    d.opcode = op; d.param = 3'd0; d.size = 3'd2; d.source = 8'h00; d.sink = 1'b0;
    d.denied = denied; d.corrupt = corrupt; d.data = data;
    return d;
  endfunction

  // Monitor: A handshakes, APB completions, A stability while stalled.
  A_chan_bits_t prev_a;
  bit           stalled_prev = 1'b0;
  always @(negedge clk) begin
    if (TL_A_valid_o && TL_D_ready_o) overlap_viol++;
    if (stalled_prev && TL_A_valid_o)
      chk(TL_A_bits_o == prev_a, "a_stable", 128'(TL_A_bits_o), 128'(prev_a));
    stalled_prev = TL_A_valid_o && !TL_A_ready_i && !rst_i;
    prev_a       = TL_A_bits_o;
    if (TL_A_valid_o && TL_A_ready_i) begin
      if (exp_a_q.size() == 0) chk(1'b0, "a_unexpected", 128'(TL_A_bits_o), 128'(0));
      else begin
        A_chan_bits_t e;
        e = exp_a_q.pop_front();
        chk(TL_A_bits_o == e, "a_bits", 128'(TL_A_bits_o), 128'(e));
      end
    end
    if (pready_o) begin
      if (exp_r_q.size() == 0) chk(1'b0, "pready_unexpected", {pslverr_o, prdata_o}, 128'(0));
      else begin
        logic [32:0] e;
        e = exp_r_q.pop_front();
        chk({pslverr_o, prdata_o} == e, "apb_resp", {pslverr_o, prdata_o}, e);
      end
    end
  end

  // One APB transfer with a scripted TL responder.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int a_stall, input int d_stall, input D_chan_bits_t dbeat,
                      input A_chan_bits_t exp_a, input logic [31:0] exp_rdata,
                      input bit exp_err, input bit drop, input int exp_len);
    int  n, acc;
    bit  hs, seen;
    exp_a_q.push_back(exp_a);
    if (!drop) exp_r_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
    @(posedge clk); #1;
    penable_i = 1'b1; acc = 1;
    n = 0; hs = 1'b0;
    while (!hs && n < 40) begin
      TL_A_ready_i = (n >= a_stall);
      @(negedge clk); hs = TL_A_valid_o && TL_A_ready_i;
      @(posedge clk); #1; n++; acc++;
    end
    TL_A_ready_i = 1'b0;
    if (!hs) chk(1'b0, "a_timeout", 128'(n), 128'(a_stall));
    if (drop) begin psel_i = 1'b0; penable_i = 1'b0; end
    TL_D_bits_i = dbeat;
    n = 0; hs = 1'b0;
    while (!hs && n < 40) begin
      TL_D_valid_i = (n >= d_stall);
      @(negedge clk); hs = TL_D_ready_o && TL_D_valid_i;
      @(posedge clk); #1; n++; acc++;
    end
    TL_D_valid_i = 1'b0;
    chk(hs, "d_handshake", 128'(hs), 128'(1));
    if (!drop) begin
      @(negedge clk);
      chk(pready_o === 1'b1, "pready_cycle", 128'(pready_o), 128'(1));
      chk(acc == exp_len, "access_len", 128'(acc), 128'(exp_len));
      @(posedge clk); #1;
      psel_i = 1'b0; penable_i = 1'b0;
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); if (pready_o) seen = 1'b1;
      end
      chk(!seen, "abort_no_pready", 128'(seen), 128'(0));
    end
  endtask

  initial begin
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; TL_A_ready_i = 1'b0; TL_D_valid_i = 1'b0;
    TL_D_bits_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({TL_A_valid_o, TL_D_ready_o, pready_o, pslverr_o} == 4'b0, "reset_ctl",
        128'({TL_A_valid_o, TL_D_ready_o, pready_o, pslverr_o}), 128'(0));
    chk(prdata_o == 32'h0, "reset_prdata", 128'(prdata_o), 128'(0));
    chk(TL_A_bits_o == '0, "reset_a_bits", 128'(TL_A_bits_o), 128'(0));
    @(posedge clk); #1 rst_i = 1'b0;

    // best-case write, upper lane
    xfer(1, 32'h104, 32'hDEADBEEF, 0, 0, mk_d(ACCESS_ACK, 0, 0, 64'h0),
         mk_a(PUT_FULL_DATA, 32'h104, 8'hF0, 64'hDEADBEEF_00000000), 32'h0, 0, 0, 3);
    // reads of both lanes
    xfer(0, 32'h200, 32'h0, 0, 0, mk_d(ACCESS_ACK_DATA, 0, 0, 64'h11223344_55667788),
         mk_a(GET, 32'h200, 8'h0F, 64'h0), 32'h55667788, 0, 0, 3);
    xfer(0, 32'h204, 32'h0, 0, 0, mk_d(ACCESS_ACK_DATA, 0, 0, 64'h11223344_55667788),
         mk_a(GET, 32'h204, 8'hF0, 64'h0), 32'h11223344, 0, 0, 3);
    // stalled A (5) and D (3), lower-lane write
    xfer(1, 32'h008, 32'hCAFEF00D, 5, 3, mk_d(ACCESS_ACK, 0, 0, 64'h0),
         mk_a(PUT_FULL_DATA, 32'h008, 8'h0F, 64'h00000000_CAFEF00D), 32'h0, 0, 0, 11);
    // error cases
    xfer(0, 32'h010, 32'h0, 0, 0, mk_d(ACCESS_ACK_DATA, 0, 1, 64'hAAAABBBB_CCCCDDDD),
         mk_a(GET, 32'h010, 8'h0F, 64'h0), 32'hCCCCDDDD, 1, 0, 3);
    xfer(1, 32'h014, 32'h12345678, 0, 1, mk_d(ACCESS_ACK, 1, 0, 64'h0),
         mk_a(PUT_FULL_DATA, 32'h014, 8'hF0, 64'h12345678_00000000), 32'h0, 1, 0, 4);
    xfer(1, 32'h018, 32'h0BADF00D, 0, 0, mk_d(ACCESS_ACK_DATA, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF),
         mk_a(PUT_FULL_DATA, 32'h018, 8'h0F, 64'h00000000_0BADF00D), 32'h0, 1, 0, 3);
    // abort during WAIT_D, then a normal write
    xfer(0, 32'h020, 32'h0, 0, 2, mk_d(ACCESS_ACK_DATA, 0, 0, 64'h0F0F0F0F_F0F0F0F0),
         mk_a(GET, 32'h020, 8'h0F, 64'h0), 32'h0, 0, 1, 0);
    xfer(1, 32'h024, 32'h55AA55AA, 1, 0, mk_d(ACCESS_ACK, 0, 0, 64'h0),
         mk_a(PUT_FULL_DATA, 32'h024, 8'hF0, 64'h55AA55AA_00000000), 32'h0, 0, 0, 4);

    // reset pulsed while the A request is stalled
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h300; pwdata_i = '0;
    @(posedge clk); #1 penable_i = 1'b1;
    @(negedge clk);
    chk(TL_A_valid_o === 1'b1, "rst_pre_valid", 128'(TL_A_valid_o), 128'(1));
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk);
    chk({TL_A_valid_o, TL_D_ready_o, pready_o} == 3'b0, "rst_mid_ctl",
        128'({TL_A_valid_o, TL_D_ready_o, pready_o}), 128'(0));
    chk(TL_A_bits_o == '0, "rst_mid_bits", 128'(TL_A_bits_o), 128'(0));

    // read after reset; low address bits ignored
    xfer(0, 32'h30E, 32'h0, 0, 0, mk_d(ACCESS_ACK_DATA, 0, 0, 64'h89ABCDEF_01234567),
         mk_a(GET, 32'h30C, 8'hF0, 64'h0), 32'h89ABCDEF, 0, 0, 3);

    repeat (3) @(posedge clk);
    chk(exp_a_q.size() == 0, "a_queue_drained", 128'(exp_a_q.size()), 128'(0));
    chk(exp_r_q.size() == 0, "r_queue_drained", 128'(exp_r_q.size()), 128'(0));
    chk(overlap_viol == 0, "a_d_overlap", 128'(overlap_viol), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
